// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types for the PLL reset sequencer: state encoding and counter width.
package pll_seq_pkg;

    localparam int PLL_SEQ_CNT_W = 17;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        HOLD      = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_seq_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Generic two-flop synchroniser, async active-low reset, resets to 0.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock-filter / system-reset sequencer on refclk.
// Optional lock-loss counter: define PLL_RESET_SEQUENCER_LOSS_CNT_EN.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int HOLD_CYCLES  = 64,
    parameter int LOSS_FILTER  = 4,
    parameter int MAX_RETRY    = 7
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       soft_rst_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [2:0] state_o,
    output logic [2:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam int CNT_W = PLL_SEQ_CNT_W;
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LOSS_FILTER - 1);
    localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRY);

    logic lk_s;

    pll_seq_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stab_q, stab_d;
    logic [CNT_W-1:0] lo_q, lo_d;
    logic [2:0]       retry_q, retry_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_n_q, sys_rst_n_d;

    sync_2ff #(.W(1)) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lk_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        stab_d  = '0;
        lo_d    = '0;
        retry_d = retry_q;

        case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                stab_d = lk_s ? stab_q + 1'b1 : '0;
                // A completed stable run beats a simultaneous timeout.
                if (lk_s && (stab_q == STAB_LAST)) begin
                    state_d = HOLD;
                    retry_d = '0;
                end else if (cnt_q == TO_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = FAIL;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = PLL_RST;
                    end
                end
            end
            HOLD: begin
                if (!lk_s)                   state_d = PLL_RST;
                else if (soft_rst_req)       cnt_d   = '0;
                else if (cnt_q == HOLD_LAST) state_d = RUN;
            end
            RUN: begin
                lo_d = lk_s ? '0 : lo_q + 1'b1;
                if (!lk_s && (lo_q == LOSS_LAST)) state_d = PLL_RST;
                else if (soft_rst_req)            state_d = HOLD;
            end
            FAIL: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = PLL_RST;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d  = '0;
            stab_d = '0;
            lo_d   = '0;
        end

        // Outputs lag the state by one cycle so they come straight from flops.
        pll_rst_d   = (state_q == PLL_RST) || (state_q == FAIL);
        sys_rst_n_d = (state_q == RUN);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            stab_q      <= '0;
            lo_q        <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stab_q      <= stab_d;
            lo_q        <= lo_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
        end
    end

`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
    logic       loss_evt;
    logic [7:0] loss_q, loss_d;

    always_comb begin
        loss_evt = (state_q == RUN) && !lk_s && (lo_q == LOSS_LAST);
        loss_d   = loss_evt ? sat_inc8(loss_q) : loss_q;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) loss_q <= '0;
        else        loss_q <= loss_d;
    end

    assign loss_cnt = loss_q;
`else
    assign loss_cnt = '0;
`endif

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign ready     = (state_q == RUN);
    assign fail      = (state_q == FAIL);
    assign state_o   = state_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer with shortened timing parameters.
module tb_pll_reset_sequencer;

    localparam int RST_CYCLES   = 4;
    localparam int LOCK_STABLE  = 8;
    localparam int LOCK_TIMEOUT = 32;
    localparam int HOLD_CYCLES  = 6;
    localparam int LOSS_FILTER  = 3;
    localparam int MAX_RETRY    = 2;

`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
    localparam int LOSS_EXP = 1;
`else
    localparam int LOSS_EXP = 0;
`endif

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic [2:0] state_o;
    logic [2:0] retry_cnt;
    logic [7:0] loss_cnt;

    always #5 refclk = ~refclk;

    pll_reset_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_STABLE  (LOCK_STABLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .LOSS_FILTER  (LOSS_FILTER),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .pll_rst      (pll_rst),
        .sys_rst_n    (sys_rst_n),
        .ready        (ready),
        .fail         (fail),
        .state_o      (state_o),
        .retry_cnt    (retry_cnt),
        .loss_cnt     (loss_cnt)
    );

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_mis = 0;

    task automatic chk_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input int obs);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL sb_underflow: got %0d expected none", obs);
        end else begin
            e = sb.pop_front();
            chk_val(e.tag, obs, e.val);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        sb_push({pfx, "_state"}, 0);
        sb_push({pfx, "_pll_rst"}, 1);
        sb_push({pfx, "_sys_rst_n"}, 0);
        sb_push({pfx, "_ready"}, 0);
        sb_push({pfx, "_fail"}, 0);
        sb_push({pfx, "_retry"}, 0);
        sb_push({pfx, "_loss"}, 0);
        sb_pop(int'(state_o));
        sb_pop(int'(pll_rst));
        sb_pop(int'(sys_rst_n));
        sb_pop(int'(ready));
        sb_pop(int'(fail));
        sb_pop(int'(retry_cnt));
        sb_pop(int'(loss_cnt));
    endtask

    // Leaves rst_n released on a falling edge; the next rising edge is cycle 1.
    task automatic do_reset(input string pfx, input logic lock);
        rst_n        = 1'b0;
        soft_rst_req = 1'b0;
        pll_locked   = lock;
        repeat (3) @(negedge refclk);
        check_reset_vals(pfx);
        rst_n = 1'b1;
    endtask

    initial begin
        int hi, rdy_at, sr_at, st0_at, sr0_at, loss_v, not_run, hold_at;
        int fall_at, rise_at, low_n, pr_hi, fail_at, r50, r90;
        bit got;

        // Nominal bring-up: lock arrives on cycle 10.
        do_reset("rst0", 1'b0);
        sb_push("nom_pll_rst_cycles", RST_CYCLES);
        sb_push("nom_ready_at", 10 + 2 + LOCK_STABLE + HOLD_CYCLES);
        sb_push("nom_sys_rst_n_at", 10 + 2 + LOCK_STABLE + HOLD_CYCLES + 1);
        hi = 0; rdy_at = -1; sr_at = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge refclk);
            if (pll_rst) hi++;
            if (rdy_at < 0 && ready) rdy_at = i;
            if (sr_at < 0 && sys_rst_n) sr_at = i;
            if (i == 10) pll_locked = 1'b1;
        end
        sb_pop(hi);
        sb_pop(rdy_at);
        sb_pop(sr_at);
        sb_push("nom_state", 3);
        sb_push("nom_retry", 0);
        sb_push("nom_fail", 0);
        sb_pop(int'(state_o));
        sb_pop(int'(retry_cnt));
        sb_pop(int'(fail));

        // Two-cycle lock drop in RUN is filtered out.
        sb_push("glitch2_not_run", 0);
        pll_locked = 1'b0;
        not_run = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge refclk);
            if (state_o != 3'd3 || !sys_rst_n) not_run++;
            if (i == 2) pll_locked = 1'b1;
        end
        sb_pop(not_run);

        // Three-cycle drop is a lock loss.
        sb_push("glitch3_pll_rst_at", 2 + LOSS_FILTER);
        sb_push("glitch3_sys_rst_n_lo_at", 2 + LOSS_FILTER + 1);
        sb_push("glitch3_loss_cnt", LOSS_EXP);
        pll_locked = 1'b0;
        st0_at = -1; sr0_at = -1; loss_v = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge refclk);
            if (st0_at < 0 && state_o == 3'd0) st0_at = i;
            if (sr0_at < 0 && !sys_rst_n) sr0_at = i;
            if (i == 8) loss_v = int'(loss_cnt);
            if (i == 3) pll_locked = 1'b1;
        end
        sb_pop(st0_at);
        sb_pop(sr0_at);
        sb_pop(loss_v);

        sb_push("relock_ready", 1);
        got = 1'b0;
        for (int i = 1; i <= 100 && !got; i++) begin
            @(negedge refclk);
            if (ready) got = 1'b1;
        end
        sb_pop(int'(got));

        // Soft reset held for 10 cycles from RUN.
        sb_push("soft_hold_at", 1);
        sb_push("soft_sys_lo_at", 2);
        sb_push("soft_sys_hi_at", 10 + HOLD_CYCLES + 1);
        sb_push("soft_low_cycles", 10 + HOLD_CYCLES - 1);
        sb_push("soft_pll_rst_hi", 0);
        soft_rst_req = 1'b1;
        hold_at = -1; fall_at = -1; rise_at = -1; low_n = 0; pr_hi = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge refclk);
            if (hold_at < 0 && state_o == 3'd2) hold_at = i;
            if (fall_at < 0 && !sys_rst_n) fall_at = i;
            if (fall_at >= 0 && rise_at < 0 && sys_rst_n) rise_at = i;
            if (!sys_rst_n) low_n++;
            if (pll_rst) pr_hi++;
            if (i == 10) soft_rst_req = 1'b0;
        end
        sb_pop(hold_at);
        sb_pop(fall_at);
        sb_pop(rise_at);
        sb_pop(low_n);
        sb_pop(pr_hi);

        // Lock never arrives: retries exhaust into the sticky failure state.
        do_reset("rst1", 1'b0);
        sb_push("nolock_retry_c50", 1);
        sb_push("nolock_retry_c90", 2);
        sb_push("nolock_fail_at", (MAX_RETRY + 1) * (RST_CYCLES + LOCK_TIMEOUT));
        sb_push("nolock_pll_rst", 1);
        sb_push("nolock_sys_rst_n", 0);
        sb_push("nolock_state", 4);
        fail_at = -1; r50 = -1; r90 = -1;
        for (int i = 1; i <= 160; i++) begin
            @(negedge refclk);
            if (i == 50) r50 = int'(retry_cnt);
            if (i == 90) r90 = int'(retry_cnt);
            if (fail_at < 0 && fail) fail_at = i;
        end
        sb_pop(r50);
        sb_pop(r90);
        sb_pop(fail_at);
        sb_pop(int'(pll_rst));
        sb_pop(int'(sys_rst_n));
        sb_pop(int'(state_o));

        // Lock bounce in WAIT_LOCK: high 7, low 1, then high.
        do_reset("rst2", 1'b0);
        sb_push("bounce_hold_at", 10 + 2 + 7 + 1 + LOCK_STABLE);
        sb_push("bounce_state_c30", 2);
        hold_at = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge refclk);
            if (hold_at < 0 && state_o == 3'd2) hold_at = i;
            if (i == 10) pll_locked = 1'b1;
            if (i == 17) pll_locked = 1'b0;
            if (i == 18) pll_locked = 1'b1;
        end
        sb_pop(hold_at);
        sb_pop(int'(state_o));

        // Asynchronous reset in the middle of HOLD, between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async");
        @(negedge refclk);
        rst_n = 1'b1;

        if (sb.size() != 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL sb_leftover: got %0d expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
